// File: rtl/ghash_acc.sv
// ghash_acc: sequential GHASH accumulator wrapped around an external gf_mul_128.
// Each accepted block X produces Y <= (Y ^ X) * H. After the block flagged
// last, the final Y is held on tag until tag_ready.
// The multiplier sits beside this block; it is reached only through mul_a,
// mul_b (registered operands) and mul_c (reduced product). mul_c is sampled
// MUL_LAT cycles after the operands are launched.
// Optional feature: define GHASH_BLK_CNT_EN to add the blk_cnt output, which
// counts accepted blocks per message.
module ghash_acc #(
  parameter int MUL_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         h_load,
  input  logic [127:0] h_in,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_data,
  input  logic         blk_last,
  output logic [127:0] mul_a,
  output logic [127:0] mul_b,
  input  logic [127:0] mul_c,
  output logic         tag_valid,
  input  logic         tag_ready,
  output logic [127:0] tag,
  output logic         busy
`ifdef GHASH_BLK_CNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Launch cycle is counted separately, so the counter starts one short.
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_t       state_q;
  logic [127:0] h_q;
  logic [127:0] y_q;
  logic [127:0] mul_a_q;
  logic [127:0] mul_b_q;
  logic [127:0] tag_q;
  logic         tag_valid_q;
  logic         last_q;
  logic [3:0]   cnt_q;
  logic         blk_accept_s;
`ifdef GHASH_BLK_CNT_EN
  logic [31:0]  blk_cnt_q;
`endif

  // Ready only while waiting for a block; a key load in the same cycle wins.
  always_comb begin
    blk_ready = 1'b0;
    if (state_q == S_ACC) begin
      blk_ready = !h_load;
    end else begin
      blk_ready = 1'b0;
    end
  end

  assign blk_accept_s = blk_valid && blk_ready;

  // Main controller: key load, block accept, product capture, tag handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      h_q         <= 128'd0;
      y_q         <= 128'd0;
      mul_a_q     <= 128'd0;
      mul_b_q     <= 128'd0;
      tag_q       <= 128'd0;
      tag_valid_q <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= 4'd0;
`ifdef GHASH_BLK_CNT_EN
      blk_cnt_q   <= 32'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (h_load) begin
            h_q     <= h_in;
            y_q     <= 128'd0;
`ifdef GHASH_BLK_CNT_EN
            blk_cnt_q <= 32'd0;
`endif
            state_q <= S_ACC;
          end
        end
        S_ACC: begin
          if (h_load) begin
            // Re-key starts a fresh message.
            h_q <= h_in;
            y_q <= 128'd0;
`ifdef GHASH_BLK_CNT_EN
            blk_cnt_q <= 32'd0;
`endif
          end else if (blk_accept_s) begin
            mul_a_q <= y_q ^ blk_data;
            mul_b_q <= h_q;
            last_q  <= blk_last;
            cnt_q   <= CNT_INIT;
`ifdef GHASH_BLK_CNT_EN
            blk_cnt_q <= blk_cnt_q + 32'd1;
`endif
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          if (cnt_q == 4'd0) begin
            y_q <= mul_c;
            if (last_q) begin
              tag_q       <= mul_c;
              tag_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_ACC;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          // Key is kept across messages; only the accumulator is cleared.
          if (tag_ready) begin
            tag_valid_q <= 1'b0;
            y_q         <= 128'd0;
`ifdef GHASH_BLK_CNT_EN
            blk_cnt_q   <= 32'd0;
`endif
            state_q     <= S_ACC;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign tag       = tag_q;
  assign tag_valid = tag_valid_q;
  assign busy      = (state_q == S_MUL) || (state_q == S_DONE);
`ifdef GHASH_BLK_CNT_EN
  assign blk_cnt   = blk_cnt_q;
`endif

endmodule

// File: tb/tb_ghash_acc.sv
// Directed bench for ghash_acc with a behavioural GF(2^128) multiplier in the
// loop (MUL_LAT cycles from operands to sampled product).
module tb_ghash_acc;

  localparam int MUL_LAT = 4;
  localparam logic [127:0] ONE_H = 128'h80000000_00000000_00000000_00000000;

  logic         clk = 1'b0;
  logic         rst;
  logic         h_load;
  logic [127:0] h_in;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic         blk_last;
  logic [127:0] mul_a;
  logic [127:0] mul_b;
  logic [127:0] mul_c;
  logic         tag_valid;
  logic         tag_ready;
  logic [127:0] tag;
  logic         busy;
`ifdef GHASH_BLK_CNT_EN
  logic [31:0]  blk_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  ghash_acc #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .h_load(h_load), .h_in(h_in),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_last(blk_last), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .tag_valid(tag_valid), .tag_ready(tag_ready), .tag(tag), .busy(busy)
`ifdef GHASH_BLK_CNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  // GCM bit order: bit 127 is the x^0 coefficient.
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    logic [127:0] v;
    z = 128'd0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'hE1, 120'd0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  logic [127:0] prod_s;
  logic [127:0] pipe [0:MUL_LAT-2];
  assign prod_s = gf_mul(mul_a, mul_b);
  always @(posedge clk) begin
    pipe[0] <= prod_s;
    for (int i = 1; i < MUL_LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_c = pipe[MUL_LAT-2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    h_load = 1'b1;
    h_in   = k;
    @(negedge clk);
    h_load = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] d, input logic l, output int unsigned acc_cyc);
    logic ok;
    ok = 1'b0;
    acc_cyc = 0;
    blk_valid = 1'b1;
    blk_data  = d;
    blk_last  = l;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (blk_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check_eq("blk_accepted", 128'(ok), 128'd1);
    @(negedge clk);
    blk_valid = 1'b0;
    blk_last  = 1'b0;
  endtask

  task automatic wait_tag(output logic [127:0] t, output int unsigned tc);
    logic ok;
    ok = 1'b0;
    t  = 128'd0;
    tc = 0;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (tag_valid) begin
        ok = 1'b1;
        t  = tag;
        tc = cyc;
        break;
      end
      @(negedge clk);
    end
    check_eq("tag_valid_seen", 128'(ok), 128'd1);
  endtask

  task automatic tag_handshake();
    tag_ready = 1'b1;
    @(negedge clk);
    tag_ready = 1'b0;
  endtask

  task automatic wait_not_busy();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("back_to_acc", 128'(ok), 128'd1);
  endtask

  initial begin
    logic [127:0] t;
    int unsigned c0;
    int unsigned c1;
    int unsigned tc;
    rst = 1'b1; h_load = 1'b0; h_in = 128'd0; blk_valid = 1'b0;
    blk_data = 128'd0; blk_last = 1'b0; tag_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_mul_a", mul_a, 128'd0);
    check_eq("rst_mul_b", mul_b, 128'd0);
    check_eq("rst_tag", tag, 128'd0);
    check_eq("rst_tag_valid", 128'(tag_valid), 128'd0);
    check_eq("rst_blk_ready", 128'(blk_ready), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    rst = 1'b0;

    // IDLE never accepts a block
    blk_valid = 1'b1;
    @(negedge clk);
    #1;
    check_eq("idle_blk_ready", 128'(blk_ready), 128'd0);
    check_eq("idle_busy", 128'(busy), 128'd0);
    blk_valid = 1'b0;

    // Identity key: tag is XOR of blocks, latency 2*(MUL_LAT+1)
    load_key(ONE_H);
    #1;
    check_eq("acc_blk_ready", 128'(blk_ready), 128'd1);
    send_block({16{8'h01}}, 1'b0, c0);
    check_eq("mul_b_is_h", mul_b, ONE_H);
    check_eq("mul_a_first", mul_a, {16{8'h01}});
    send_block({16{8'h02}}, 1'b1, c1);
    check_eq("mul_a_second", mul_a, {16{8'h03}});
    wait_tag(t, tc);
    check_eq("ident_tag", t, {16{8'h03}});
    check_eq("ident_latency", 128'(tc - c0), 128'(2 * (MUL_LAT + 1)));
    tag_handshake();
    #1;
    check_eq("ident_tag_valid_clr", 128'(tag_valid), 128'd0);

    // GCM test case 2 GHASH
    load_key(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    send_block(128'h0388dace60b6a392f328c2b971b2fe78, 1'b0, c0);
    send_block(128'h00000000000000000000000000000080, 1'b1, c0);
    wait_tag(t, tc);
    check_eq("gcm2_tag", t, 128'hf38cbb1ad69223dcc3457ae5b6b0f885);
    tag_handshake();

    // DONE holds the tag for 10 cycles, ignoring h_load
    load_key(ONE_H);
    send_block({16{8'h11}}, 1'b1, c0);
    wait_tag(t, tc);
    for (int i = 0; i < 10; i++) begin
      h_load = 1'b1;
      h_in   = {16{8'h5a}};
      @(negedge clk);
      #1;
      check_eq("done_tag_hold", tag, {16{8'h11}});
      check_eq("done_valid_hold", 128'(tag_valid), 128'd1);
      check_eq("done_blk_ready", 128'(blk_ready), 128'd0);
    end
    h_load = 1'b0;
    tag_ready = 1'b1;
    @(negedge clk);
    tag_ready = 1'b0;
    #1;
    check_eq("hs_valid_low", 128'(tag_valid), 128'd0);
    check_eq("hs_busy_low", 128'(busy), 128'd0);
    check_eq("hs_blk_ready", 128'(blk_ready), 128'd1);
    send_block({16{8'h22}}, 1'b1, c0);
    wait_tag(t, tc);
    check_eq("after_hs_tag", t, {16{8'h22}});
    tag_handshake();

    // h_load and blk_valid together: key wins, Y cleared, new key used
    send_block({16{8'h0f}}, 1'b0, c0);
    wait_not_busy();
    h_load    = 1'b1;
    h_in      = 128'h40000000_00000000_00000000_00000000;
    blk_valid = 1'b1;
    blk_data  = 128'd1;
    blk_last  = 1'b1;
    #1;
    check_eq("hload_blk_ready", 128'(blk_ready), 128'd0);
    @(negedge clk);
    h_load = 1'b0;
    #1;
    check_eq("hload_not_accepted", 128'(busy), 128'd0);
    send_block(128'd1, 1'b1, c0);
    check_eq("hload_mul_a", mul_a, 128'd1);
    check_eq("hload_mul_b", mul_b, 128'h40000000_00000000_00000000_00000000);
    wait_tag(t, tc);
    check_eq("hload_tag", t, 128'he1000000_00000000_00000000_00000000);
    tag_handshake();

    // Reset in the second MUL cycle
    load_key(ONE_H);
    send_block({16{8'h33}}, 1'b0, c0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mulrst_mul_a", mul_a, 128'd0);
    check_eq("mulrst_mul_b", mul_b, 128'd0);
    check_eq("mulrst_tag", tag, 128'd0);
    check_eq("mulrst_tag_valid", 128'(tag_valid), 128'd0);
    check_eq("mulrst_busy", 128'(busy), 128'd0);
    blk_valid = 1'b1;
    blk_data  = {16{8'h77}};
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("mulrst_no_accept", 128'(blk_ready), 128'd0);
      @(negedge clk);
      #1;
      check_eq("mulrst_idle_busy", 128'(busy), 128'd0);
    end
    blk_valid = 1'b0;
    @(negedge clk);
    load_key(ONE_H);
    send_block({16{8'h44}}, 1'b1, c0);
    wait_tag(t, tc);
    check_eq("mulrst_next_tag", t, {16{8'h44}});
    tag_handshake();

`ifdef GHASH_BLK_CNT_EN
    // Block counter: 5-block message, clear on handshake, wrap
    for (int k = 1; k <= 5; k++) begin
      send_block({16{8'(k)}}, (k == 5), c0);
    end
    wait_tag(t, tc);
    check_eq("cnt_tag", t, {16{8'h01}});
    check_eq("cnt_five", 128'(blk_cnt), 128'd5);
    tag_handshake();
    #1;
    check_eq("cnt_cleared", 128'(blk_cnt), 128'd0);
    force dut.blk_cnt_q = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.blk_cnt_q;
    send_block({16{8'h55}}, 1'b1, c0);
    check_eq("cnt_wrap", 128'(blk_cnt), 128'd0);
    wait_tag(t, tc);
    tag_handshake();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
